// File: rtl/tree_bank_mem_if.sv
// Bus bundle for tree_bank_mem: load write port, lookup request port and response port.
// A transfer on any channel happens on the rising edge where its valid and ready are both 1. The payload must hold steady while valid waits for ready.
interface tree_bank_mem_if #(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int TREE_W     = 3
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [TREE_W-1:0]     ld_tree;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [NODE_WIDTH-1:0] ld_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [TREE_W-1:0]     rd_tree;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [NODE_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic [TREE_W-1:0]     rsp_tree;

  modport master (
    output ld_valid, ld_tree, ld_addr, ld_data,
    output rd_valid, rd_tree, rd_addr, rsp_ready,
    input  ld_ready, rd_ready, rsp_valid, rsp_data, rsp_err, rsp_tree
  );

  modport slave (
    input  ld_valid, ld_tree, ld_addr, ld_data,
    input  rd_valid, rd_tree, rd_addr, rsp_ready,
    output ld_ready, rd_ready, rsp_valid, rsp_data, rsp_err, rsp_tree
  );
endinterface

// File: rtl/tree_bank_mem.sv
// Multi-tree node memory: one shared RAM holding NUM_TREES banks, a load port,
// and a two-stage lookup pipeline that feeds a 2-entry in-order response FIFO.
module tree_bank_mem #(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int TREE_DEPTH = 512,
  parameter int NUM_TREES  = 8,
  parameter int TREE_W     = 3
) (
  input  logic           clk,
  input  logic           rst,
  tree_bank_mem_if.slave bus
);
  localparam int MEM_WORDS = NUM_TREES * TREE_DEPTH;
  localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int NT_SLOTS  = 2 ** TREE_W;

  logic [NODE_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [NT_SLOTS-1:0]   r_loaded;

  logic                  r_s1_valid;
  logic                  r_s1_err;
  logic [TREE_W-1:0]     r_s1_tree;
  logic [NODE_WIDTH-1:0] r_s1_data;

  logic [NODE_WIDTH-1:0] r_fifo_data [2];
  logic [TREE_W-1:0]     r_fifo_tree [2];
  logic [1:0]            r_fifo_err;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_ld_fire;
  logic                  w_ld_ok;
  logic [IDX_W-1:0]      w_ld_idx;
  logic                  w_rd_fire;
  logic                  w_rd_err;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rsp_valid;
  logic                  w_pop;
  logic [2:0]            w_occ;

  assign w_ld_fire = bus.ld_valid && bus.ld_ready;
  assign w_ld_ok   = ({1'b0, bus.ld_tree} < (TREE_W+1)'(NUM_TREES)) &&
                     ({1'b0, bus.ld_addr} < (ADDR_WIDTH+1)'(TREE_DEPTH));
  assign w_ld_idx  = IDX_W'(bus.ld_tree) * IDX_W'(TREE_DEPTH) + IDX_W'(bus.ld_addr);

  // Unloaded trees and out-of-range coordinates answer with an error instead of data.
  assign w_rd_err  = !(({1'b0, bus.rd_tree} < (TREE_W+1)'(NUM_TREES)) &&
                       ({1'b0, bus.rd_addr} < (ADDR_WIDTH+1)'(TREE_DEPTH)) &&
                       r_loaded[bus.rd_tree]);
  assign w_rd_idx  = IDX_W'(bus.rd_tree) * IDX_W'(TREE_DEPTH) + IDX_W'(bus.rd_addr);

  assign w_rsp_valid = (r_count != 2'd0);
  assign w_pop       = w_rsp_valid && bus.rsp_ready;
  // Slots committed after this edge: buffered plus in flight, minus what drains now.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_s1_valid} - {2'b00, w_pop};

  assign bus.ld_ready = !rst;
  assign bus.rd_ready = !bus.ld_valid && !rst && (w_occ < 3'd2);
  assign w_rd_fire    = bus.rd_valid && bus.rd_ready;

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_rsp_valid ? r_fifo_data[r_rptr] : '0;
  assign bus.rsp_err   = w_rsp_valid ? r_fifo_err[r_rptr]  : 1'b0;
  assign bus.rsp_tree  = w_rsp_valid ? r_fifo_tree[r_rptr] : '0;

  // Datapath storage carries no reset; validity is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (w_ld_fire && w_ld_ok) begin
      r_mem[w_ld_idx] <= bus.ld_data;
    end
    if (w_rd_fire) begin
      r_s1_err  <= w_rd_err;
      r_s1_tree <= bus.rd_tree;
      if (!w_rd_err) begin
        r_s1_data <= r_mem[w_rd_idx];
      end else begin
        r_s1_data <= '0;
      end
    end
    if (r_s1_valid) begin
      r_fifo_data[r_wptr] <= r_s1_data;
      r_fifo_err[r_wptr]  <= r_s1_err;
      r_fifo_tree[r_wptr] <= r_s1_tree;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loaded   <= '0;
      r_s1_valid <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_ld_fire && w_ld_ok) begin
        r_loaded[bus.ld_tree] <= 1'b1;
      end
      r_s1_valid <= w_rd_fire;
      if (r_s1_valid) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_s1_valid} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_tree_bank_mem.sv
// Self-checking bench for tree_bank_mem: reference model of RAM and loaded bitmap,
// expected-response queue popped whenever the DUT hands over a response.
module tb_tree_bank_mem;
  localparam int NW = 120;
  localparam int AW = 10;
  localparam int TD = 512;
  localparam int NT = 8;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tree_bank_mem_if #(.NODE_WIDTH(NW), .ADDR_WIDTH(AW), .TREE_W(TW)) bus ();
  tree_bank_mem_if #(.NODE_WIDTH(NW), .ADDR_WIDTH(AW), .TREE_W(TW)) bus2 ();

  tree_bank_mem #(.NODE_WIDTH(NW), .ADDR_WIDTH(AW), .TREE_DEPTH(TD),
                  .NUM_TREES(NT), .TREE_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tree_bank_mem #(.NODE_WIDTH(NW), .ADDR_WIDTH(AW), .TREE_DEPTH(TD),
                  .NUM_TREES(6), .TREE_W(TW)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit lat_chk  = 1'b1;

  logic [NW-1:0]   m_mem [NT*TD];
  logic [NT-1:0]   m_loaded;
  logic [NW+TW:0]  exp_q[$];
  int              acc_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [TW-1:0] t, input logic [AW-1:0] a, input logic [NW-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_tree  = t;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    @(negedge clk);
    check("ld_ready", bus.ld_ready, 1);
    if (bus.ld_ready && int'(t) < NT && int'(a) < TD) begin
      m_mem[int'(t)*TD + int'(a)] = d;
      m_loaded[t] = 1'b1;
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_read(input logic [TW-1:0] t, input logic [AW-1:0] a);
    logic          err;
    logic [NW-1:0] d;
    bit            done;
    done = 1'b0;
    err  = !(int'(t) < NT && int'(a) < TD && m_loaded[t]);
    d    = err ? '0 : m_mem[int'(t)*TD + int'(a)];
    bus.rd_valid = 1'b1;
    bus.rd_tree  = t;
    bus.rd_addr  = a;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.rd_ready) begin
        exp_q.push_back({err, t, d});
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("rd_accept_timeout", bus.rd_ready, 1);
    bus.rd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic b2_load(input logic [TW-1:0] t, input logic [AW-1:0] a, input logic [NW-1:0] d);
    bus2.ld_valid = 1'b1;
    bus2.ld_tree  = t;
    bus2.ld_addr  = a;
    bus2.ld_data  = d;
    @(posedge clk); #1;
    bus2.ld_valid = 1'b0;
  endtask

  task automatic b2_read(input logic [TW-1:0] t, input logic [AW-1:0] a,
                         input logic e_err, input logic [NW-1:0] e_data);
    bus2.rsp_ready = 1'b1;
    bus2.rd_valid  = 1'b1;
    bus2.rd_tree   = t;
    bus2.rd_addr   = a;
    @(negedge clk);
    check("b2_rd_ready", bus2.rd_ready, 1);
    @(posedge clk); #1;
    bus2.rd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2_rsp_valid", bus2.rsp_valid, 1);
    check("b2_rsp", {bus2.rsp_err, bus2.rsp_tree, bus2.rsp_data}, {e_err, t, e_data});
    @(posedge clk); #1;
  endtask

  // Scoreboard: a response is handed over on every edge where valid and ready are both high.
  always @(negedge clk) begin : monitor
    logic [NW+TW:0] e;
    int             a;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", bus.rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("rsp", {bus.rsp_err, bus.rsp_tree, bus.rsp_data}, e);
        if (lat_chk) check("latency", cyc - a, 2);
      end
    end
  end

  initial begin
    int c0;
    bus.ld_valid = 0; bus.ld_tree = '0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.rd_valid = 0; bus.rd_tree = '0; bus.rd_addr = '0; bus.rsp_ready = 0;
    bus2.ld_valid = 0; bus2.ld_tree = '0; bus2.ld_addr = '0; bus2.ld_data = '0;
    bus2.rd_valid = 0; bus2.rd_tree = '0; bus2.rd_addr = '0; bus2.rsp_ready = 0;
    m_loaded = '0;

    // reset values, with a lookup pending during reset
    bus.rd_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_ready", bus.rd_ready, 0);
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_tree", bus.rsp_tree, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rsp_ready = 1'b1;

    // unloaded tree answers with an error
    do_read(0, 0);
    wait_drain();

    // single load then lookup
    do_load(2, 5, 120'h0051406810000000000000600733);
    do_read(2, 5);
    wait_drain();

    // fill trees 0 and 7, then back-to-back lookups
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < TD; a++)
        do_load(TW'(k * 7), AW'(a), NW'({3'(k * 7), 10'(a)}));
    c0 = cyc;
    for (int a = 0; a < TD; a++)
      for (int k = 0; k < 2; k++)
        do_read(TW'(k * 7), AW'(a));
    check("tput_cycles", cyc - c0, 1024);
    wait_drain();

    // backpressure: two accepts fill the buffer, the rest wait
    lat_chk = 1'b0;
    bus.rsp_ready = 1'b0;
    do_read(0, 10);
    do_read(0, 11);
    bus.rd_valid = 1'b1;
    bus.rd_tree  = 0;
    bus.rd_addr  = 12;
    repeat (3) begin
      @(negedge clk);
      check("bp_rd_ready", bus.rd_ready, 0);
      check("bp_head", {bus.rsp_err, bus.rsp_tree, bus.rsp_data}, exp_q[0]);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    do_read(0, 12);
    do_read(0, 13);
    wait_drain();
    lat_chk = 1'b1;

    // out-of-range lookups and a dropped load
    do_read(0, 512);
    do_load(6, 600, 120'hDEAD_BEEF);
    do_read(7, 88);
    do_read(6, 0);
    do_read(7, 511);
    wait_drain();

    // loads hold off lookups; a lookup right after a load sees the new word
    bus.ld_valid = 1'b1; bus.ld_tree = 2; bus.ld_addr = 6; bus.ld_data = 120'h1234_5678_9ABC;
    bus.rd_valid = 1'b1; bus.rd_tree = 2; bus.rd_addr = 5;
    repeat (4) begin
      @(negedge clk);
      check("ldhold_rd_ready", bus.rd_ready, 0);
      @(posedge clk); #1;
    end
    m_mem[2*TD + 6] = 120'h1234_5678_9ABC;
    m_loaded[2] = 1'b1;
    bus.ld_valid = 1'b0;
    bus.rd_valid = 1'b0;
    do_read(2, 6);
    wait_drain();

    // reset with two responses buffered
    lat_chk = 1'b0;
    bus.rsp_ready = 1'b0;
    do_read(7, 1);
    do_read(7, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("buf_full_valid", bus.rsp_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    m_loaded = '0;
    @(negedge clk);
    check("rst2_ld_ready", bus.ld_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_quiet", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    lat_chk = 1'b1;
    do_read(2, 5);
    do_read(7, 3);
    wait_drain();

    // six-tree instance: tree 7 is out of range
    b2_load(7, 0, 120'hAB);
    b2_load(5, 0, 120'hCD);
    b2_read(7, 0, 1'b1, '0);
    b2_read(5, 0, 1'b0, 120'hCD);
    b2_read(4, 0, 1'b1, '0);

    repeat (3) @(posedge clk);
    check("leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
